// File: rtl/hist_rank_sort_pkg.sv
// Shared types and sizing for the histogram rank sorter: bin count, count and rank widths, FSM states.
package hist_rank_sort_pkg;

  localparam int NUM_BINS  = 5;
  localparam int FREQ_W    = 8;
  localparam int RANK_W    = 3;
  localparam int NUM_PAIRS = NUM_BINS / 2;

  typedef logic [FREQ_W-1:0] freq_t;
  typedef logic [RANK_W-1:0] rank_t;

  localparam rank_t LAST_PHASE = rank_t'(NUM_BINS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } sort_state_e;

endpackage

// File: rtl/hist_rank_sort_if.sv
// Histogram-in / rank-maps-out bundle of the rank sorter; master drives the histogram side.
interface hist_rank_sort_if;
  import hist_rank_sort_pkg::*;

  logic                       finish_in;
  logic [NUM_BINS*FREQ_W-1:0] freq_in;
  logic [NUM_BINS*RANK_W-1:0] rate_at_rank;
  logic [NUM_BINS*RANK_W-1:0] rank_of_rate;
  freq_t                      top_freq;
  logic                       valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output finish_in, freq_in,
    input  rate_at_rank, rank_of_rate, top_freq, valid, busy, overrun
  );

  modport slave (
    input  finish_in, freq_in,
    output rate_at_rank, rank_of_rate, top_freq, valid, busy, overrun
  );

endinterface

// File: rtl/hist_rank_sort_cmp_swap.sv
// Combinational compare-exchange of one (frequency, rate index) pair; larger count goes to hi.
module hist_rank_sort_cmp_swap
  import hist_rank_sort_pkg::*;
(
  input  freq_t a_f,
  input  rank_t a_idx,
  input  freq_t b_f,
  input  rank_t b_idx,
  output freq_t hi_f,
  output rank_t hi_idx,
  output freq_t lo_f,
  output rank_t lo_idx
);

  logic swap_s;

  // Strict less-than keeps equal counts in place, so the sort stays stable.
  assign swap_s = (a_f < b_f);
  assign hi_f   = swap_s ? b_f   : a_f;
  assign hi_idx = swap_s ? b_idx : a_idx;
  assign lo_f   = swap_s ? a_f   : b_f;
  assign lo_idx = swap_s ? a_idx : b_idx;

endmodule

// File: rtl/hist_rank_sort.sv
// Captures histogram counts and ranks rates by frequency with an odd-even transposition sort.
// Optional SORT_EARLY_EXIT_EN: finish after two consecutive swap-free phases.
module hist_rank_sort
  import hist_rank_sort_pkg::*;
(
  input logic              CLK,
  input logic              RST,
  hist_rank_sort_if.slave  bus
);

  sort_state_e state_r, state_nx_s;
  logic        fin_q_r, edge_s, sort_end_s;
  rank_t       phase_r;
  freq_t       f_r [NUM_BINS];
  freq_t       nf_s [NUM_BINS];
  rank_t       idx_r [NUM_BINS];
  rank_t       nidx_s [NUM_BINS];
  rank_t       rate_at_rank_r [NUM_BINS];
  rank_t       rank_of_rate_r [NUM_BINS];
  rank_t       rank_inv_s [NUM_BINS];
  freq_t       top_freq_r;
  logic        valid_r, busy_r, overrun_r;

  freq_t pa_f_s [NUM_PAIRS];
  freq_t pb_f_s [NUM_PAIRS];
  rank_t pa_idx_s [NUM_PAIRS];
  rank_t pb_idx_s [NUM_PAIRS];
  freq_t hi_f_s [NUM_PAIRS];
  freq_t lo_f_s [NUM_PAIRS];
  rank_t hi_idx_s [NUM_PAIRS];
  rank_t lo_idx_s [NUM_PAIRS];

  assign edge_s = bus.finish_in & ~fin_q_r;

  // Even phase pairs (2p,2p+1); odd phase pairs (2p+1,2p+2), collapsed onto one bin when out of range.
  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    localparam int OB = (2*p + 2 < NUM_BINS) ? 2*p + 2 : 2*p + 1;
    assign pa_f_s[p]   = phase_r[0] ? f_r[2*p+1]   : f_r[2*p];
    assign pa_idx_s[p] = phase_r[0] ? idx_r[2*p+1] : idx_r[2*p];
    assign pb_f_s[p]   = phase_r[0] ? f_r[OB]      : f_r[2*p+1];
    assign pb_idx_s[p] = phase_r[0] ? idx_r[OB]    : idx_r[2*p+1];

    hist_rank_sort_cmp_swap u_cmp (
      .a_f    (pa_f_s[p]),
      .a_idx  (pa_idx_s[p]),
      .b_f    (pb_f_s[p]),
      .b_idx  (pb_idx_s[p]),
      .hi_f   (hi_f_s[p]),
      .hi_idx (hi_idx_s[p]),
      .lo_f   (lo_f_s[p]),
      .lo_idx (lo_idx_s[p])
    );
  end

  for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
    freq_t ev_f, od_f;
    rank_t ev_i, od_i;
    if ((i / 2) < NUM_PAIRS) begin : g_ev
      if (i % 2 == 0) begin : g_hi
        assign ev_f = hi_f_s[i/2];
        assign ev_i = hi_idx_s[i/2];
      end else begin : g_lo
        assign ev_f = lo_f_s[i/2];
        assign ev_i = lo_idx_s[i/2];
      end
    end else begin : g_ev_keep
      assign ev_f = f_r[i];
      assign ev_i = idx_r[i];
    end
    if (i > 0 && ((i - 1) / 2) < NUM_PAIRS && ((i - 1) / 2) * 2 + 2 < NUM_BINS) begin : g_od
      if ((i - 1) % 2 == 0) begin : g_hi
        assign od_f = hi_f_s[(i-1)/2];
        assign od_i = hi_idx_s[(i-1)/2];
      end else begin : g_lo
        assign od_f = lo_f_s[(i-1)/2];
        assign od_i = lo_idx_s[(i-1)/2];
      end
    end else begin : g_od_keep
      assign od_f = f_r[i];
      assign od_i = idx_r[i];
    end
    assign nf_s[i]   = phase_r[0] ? od_f : ev_f;
    assign nidx_s[i] = phase_r[0] ? od_i : ev_i;
    assign bus.rate_at_rank[i*RANK_W +: RANK_W] = rate_at_rank_r[i];
    assign bus.rank_of_rate[i*RANK_W +: RANK_W] = rank_of_rate_r[i];
  end

`ifdef SORT_EARLY_EXIT_EN
  logic clean_r, any_swap_s;
  logic [NUM_PAIRS-1:0] swap_s;

  // Rate indices are unique, so a changed hi index means the pair was exchanged.
  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_swap
    assign swap_s[p] = (hi_idx_s[p] != pa_idx_s[p]);
  end
  assign any_swap_s = |swap_s;
  assign sort_end_s = (phase_r == LAST_PHASE) ||
                      (~any_swap_s & clean_r & (phase_r != {RANK_W{1'b0}}));

  // Remembers whether the previous phase was swap-free.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clean_r <= 1'b0;
    end else if (state_r == ST_SORT) begin
      clean_r <= ~any_swap_s;
    end else begin
      clean_r <= 1'b0;
    end
  end
`else
  assign sort_end_s = (phase_r == LAST_PHASE);
`endif

  // Inverse map: for each rate, the rank slot currently holding it.
  always_comb begin
    for (int i = 0; i < NUM_BINS; i++) begin
      rank_inv_s[i] = {RANK_W{1'b0}};
      for (int r = 0; r < NUM_BINS; r++) begin
        rank_inv_s[i] = rank_inv_s[i] |
                        ((idx_r[r] == rank_t'(i)) ? rank_t'(r) : {RANK_W{1'b0}});
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (edge_s) state_nx_s = ST_SORT; else state_nx_s = ST_IDLE;
      ST_SORT: if (sort_end_s) state_nx_s = ST_DONE; else state_nx_s = ST_SORT;
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Working registers, published maps and status pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fin_q_r    <= 1'b0;
      phase_r    <= {RANK_W{1'b0}};
      top_freq_r <= {FREQ_W{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        f_r[i]            <= {FREQ_W{1'b0}};
        idx_r[i]          <= {RANK_W{1'b0}};
        rate_at_rank_r[i] <= rank_t'(i);
        rank_of_rate_r[i] <= rank_t'(i);
      end
    end else begin
      fin_q_r   <= bus.finish_in;
      valid_r   <= 1'b0;
      overrun_r <= edge_s & (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (edge_s) begin
            phase_r <= {RANK_W{1'b0}};
            busy_r  <= 1'b1;
            for (int i = 0; i < NUM_BINS; i++) begin
              f_r[i]   <= bus.freq_in[i*FREQ_W +: FREQ_W];
              idx_r[i] <= rank_t'(i);
            end
          end
        end
        ST_SORT: begin
          phase_r <= phase_r + 3'd1;
          for (int i = 0; i < NUM_BINS; i++) begin
            f_r[i]   <= nf_s[i];
            idx_r[i] <= nidx_s[i];
          end
        end
        ST_DONE: begin
          top_freq_r <= f_r[0];
          valid_r    <= 1'b1;
          busy_r     <= 1'b0;
          for (int i = 0; i < NUM_BINS; i++) begin
            rate_at_rank_r[i] <= idx_r[i];
            rank_of_rate_r[i] <= rank_inv_s[i];
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.top_freq = top_freq_r;
  assign bus.valid    = valid_r;
  assign bus.busy     = busy_r;
  assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_hist_rank_sort.sv
// Directed self-checking bench for hist_rank_sort with hand-computed rank maps and latencies.
module tb_hist_rank_sort;
  import hist_rank_sort_pkg::*;

`ifdef SORT_EARLY_EXIT_EN
  localparam int LAT_EQ = 3;
`else
  localparam int LAT_EQ = 6;
`endif

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_mis;
  int   lat, nv, nov;

  hist_rank_sort_if bus ();

  hist_rank_sort dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] map5(input int a0, input int a1, input int a2, input int a3, input int a4);
    return {rank_t'(a4), rank_t'(a3), rank_t'(a2), rank_t'(a1), rank_t'(a0)};
  endfunction

  function automatic logic [39:0] freq5(input int a0, input int a1, input int a2, input int a3, input int a4);
    return {freq_t'(a4), freq_t'(a3), freq_t'(a2), freq_t'(a1), freq_t'(a0)};
  endfunction

  // pat bit c is the finish_in level seen by the c-th clock of the run (clock 0 is the first edge).
  task automatic run_sort(input logic [39:0] fv, input logic [7:0] pat,
                          output int lat_o, output int nv_o, output int nov_o);
    lat_o = -1;
    nv_o  = 0;
    nov_o = 0;
    bus.freq_in = fv;
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      if (c > 0) begin
        if (bus.valid) begin
          nv_o++;
          if (lat_o < 0) lat_o = c - 1;
        end
        if (bus.overrun) nov_o++;
      end
      bus.finish_in = (c < 8) ? pat[c[2:0]] : 1'b0;
    end
  endtask

  task automatic chk_maps(input string tag, input logic [14:0] e_rar, input logic [14:0] e_ror, input int e_top);
    chk_eq({tag, "_rate_at_rank"}, 32'(bus.rate_at_rank), 32'(e_rar));
    chk_eq({tag, "_rank_of_rate"}, 32'(bus.rank_of_rate), 32'(e_ror));
    chk_eq({tag, "_top_freq"}, 32'(bus.top_freq), 32'(e_top));
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    RST = 1'b0;
    bus.finish_in = 1'b0;
    bus.freq_in = '0;
    #12;
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_valid", 32'(bus.valid), 32'd0);
    chk_eq("rst_overrun", 32'(bus.overrun), 32'd0);
    chk_maps("rst", map5(0, 1, 2, 3, 4), map5(0, 1, 2, 3, 4), 0);
    @(negedge CLK);
    RST = 1'b1;

    // Distinct counts
    run_sort(freq5(1, 7, 3, 9, 2), 8'b0000_0001, lat, nv, nov);
    chk_eq("t1_latency", 32'(lat), 32'd6);
    chk_eq("t1_nvalid", 32'(nv), 32'd1);
    chk_eq("t1_noverrun", 32'(nov), 32'd0);
    chk_maps("t1", map5(3, 1, 2, 4, 0), map5(4, 1, 2, 0, 3), 9);

    // All equal
    run_sort(freq5(4, 4, 4, 4, 4), 8'b0000_0001, lat, nv, nov);
    chk_eq("t2_latency", 32'(lat), 32'(LAT_EQ));
    chk_eq("t2_nvalid", 32'(nv), 32'd1);
    chk_maps("t2", map5(0, 1, 2, 3, 4), map5(0, 1, 2, 3, 4), 4);

    // Ties resolved by lower rate first
    run_sort(freq5(0, 5, 5, 0, 5), 8'b0000_0001, lat, nv, nov);
    chk_eq("t3_latency", 32'(lat), 32'd6);
    chk_maps("t3", map5(1, 2, 4, 0, 3), map5(3, 0, 1, 4, 2), 5);

    // Second edge two clocks later is dropped
    run_sort(freq5(1, 7, 3, 9, 2), 8'b0000_0101, lat, nv, nov);
    chk_eq("t4_latency", 32'(lat), 32'd6);
    chk_eq("t4_nvalid", 32'(nv), 32'd1);
    chk_eq("t4_noverrun", 32'(nov), 32'd1);
    chk_maps("t4", map5(3, 1, 2, 4, 0), map5(4, 1, 2, 0, 3), 9);

    // Level held four cycles, full-scale counts
    run_sort(freq5(255, 0, 0, 0, 255), 8'b0000_1111, lat, nv, nov);
    chk_eq("t6_latency", 32'(lat), 32'd6);
    chk_eq("t6_nvalid", 32'(nv), 32'd1);
    chk_eq("t6_noverrun", 32'(nov), 32'd0);
    chk_maps("t6", map5(0, 4, 1, 2, 3), map5(0, 2, 3, 4, 1), 255);

    // Edge coinciding with DONE is dropped
    run_sort(freq5(0, 5, 5, 0, 5), 8'b0100_0001, lat, nv, nov);
    chk_eq("done_edge_nvalid", 32'(nv), 32'd1);
    chk_eq("done_edge_noverrun", 32'(nov), 32'd1);

    // Edge in the first IDLE cycle after DONE is accepted
    run_sort(freq5(1, 7, 3, 9, 2), 8'b1000_0001, lat, nv, nov);
    chk_eq("idle_edge_nvalid", 32'(nv), 32'd2);
    chk_eq("idle_edge_noverrun", 32'(nov), 32'd0);
    chk_maps("idle_edge", map5(3, 1, 2, 4, 0), map5(4, 1, 2, 0, 3), 9);

    // Reset asserted while phase 2 is in flight
    bus.freq_in = freq5(0, 5, 5, 0, 5);
    @(negedge CLK);
    bus.finish_in = 1'b1;
    @(negedge CLK);
    bus.finish_in = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_eq("t5_busy_before", 32'(bus.busy), 32'd1);
    RST = 1'b0;
    #1;
    chk_eq("t5_busy", 32'(bus.busy), 32'd0);
    chk_eq("t5_valid", 32'(bus.valid), 32'd0);
    chk_maps("t5", map5(0, 1, 2, 3, 4), map5(0, 1, 2, 3, 4), 0);
    @(negedge CLK);
    RST = 1'b1;
    run_sort(freq5(1, 7, 3, 9, 2), 8'b0000_0001, lat, nv, nov);
    chk_eq("t5_resort_latency", 32'(lat), 32'd6);
    chk_maps("t5_resort", map5(3, 1, 2, 4, 0), map5(4, 1, 2, 0, 3), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
